// File: rtl/des_key_schedule.sv
// DES round-subkey generator: emits K1..K16 (encrypt) or K16..K1 (decrypt) one per
// valid/ready handshake, regenerating each subkey by rotating the C/D halves in place.
module des_key_schedule (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        start_i,
    output logic        ready_o,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Table entries use DES numbering: bit 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit (i-1) set means schedule step s(i) rotates by two; s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

    stateT       state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;

    logic [55:0] pc1Key;
    logic [3:0]  roundInc;
    logic        rotTwo;

    function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1Key[55 - i] = key_i[64 - PC1_TAB[i]];
    end

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign subkey_o[47 - j] = cd_q[56 - PC2_TAB[j]];
    end

    assign roundInc = round_q + 4'd1;

    // Encrypt steps forward by s(round+2); decrypt undoes the step s(16-round) that led here.
    assign rotTwo = dec_q ? SHIFT_TWO[~round_q] : SHIFT_TWO[roundInc];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dec_d   = decrypt_i;
                    round_d = 4'd0;
                    state_d = GEN;
                    // C0/D0 equals C16/D16, so decrypt starts from the unrotated halves.
                    if (decrypt_i) begin
                        cd_d = pc1Key;
                    end else begin
                        cd_d = {rotl28(pc1Key[55:28], 1'b0), rotl28(pc1Key[27:0], 1'b0)};
                    end
                end
            end
            GEN: begin
                if (subkey_ready_i) begin
                    if (round_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        round_d = roundInc;
                        if (dec_q) begin
                            cd_d = {rotr28(cd_q[55:28], rotTwo), rotr28(cd_q[27:0], rotTwo)};
                        end else begin
                            cd_d = {rotl28(cd_q[55:28], rotTwo), rotl28(cd_q[27:0], rotTwo)};
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                round_d = 4'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o        = (state_q == IDLE);
    assign subkey_valid_o = (state_q == GEN);
    assign done_o         = (state_q == DONE);
    assign round_o        = round_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a FIPS-level subkey model fills an expected
// queue on every accepted start; a negedge monitor compares whatever the DUT presents.
module tb_des_key_schedule;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        start_i;
    logic        ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic        isDone;
        logic [3:0]  round;
        logic [47:0] subkey;
    } expT;

    expT expQ [$];

    des_key_schedule dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .start_i        (start_i),
        .ready_o        (ready_o),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_o        (round_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Subkey Kr straight from the standard: PC-1, cumulative left shift, PC-2.
    function automatic logic [47:0] modelSubkey(input logic [63:0] key, input int r);
        bit cd [56];
        bit rot [56];
        logic [47:0] k;
        int total;
        total = 0;
        for (int i = 0; i < r; i++) total += SHIFTS[i];
        for (int i = 0; i < 56; i++) cd[i] = key[64 - PC1_T[i]];
        for (int i = 0; i < 28; i++) begin
            rot[i]      = cd[(i + total) % 28];
            rot[28 + i] = cd[28 + ((i + total) % 28)];
        end
        k = '0;
        for (int j = 0; j < 48; j++) k[47 - j] = rot[PC2_T[j] - 1];
        return k;
    endfunction

    function automatic logic [47:0] expectedSubkey(input logic [63:0] key, input int r);
        logic [47:0] k;
        k = modelSubkey(key, r);
        if (((key ^ GOLD_KEY) & ~PAR_MASK) == 64'd0) begin
            if (r == 1)  k = 48'h1B02EFFC7072;
            if (r == 2)  k = 48'h79AED9DBC9E5;
            if (r == 16) k = 48'hCB3D8B0E17F5;
        end
        return k;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor/scoreboard: samples on the falling edge, away from DUT updates.
    initial begin : monitor
        expT e;
        bit  busy;
        int  cnt;
        int  stalls;
        busy = 0;
        cnt = 0;
        stalls = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                checkOutput("reset ready", 64'(ready_o), 64'd1);
                checkOutput("reset valid", 64'(subkey_valid_o), 64'd0);
                checkOutput("reset done", 64'(done_o), 64'd0);
                checkOutput("reset round", 64'(round_o), 64'd0);
                checkOutput("reset subkey", 64'(subkey_o), 64'd0);
                expQ.delete();
                busy = 0;
            end else begin
                if (busy) cnt++;
                checkOutput("ready", 64'(ready_o), 64'(expQ.size() == 0));
                if (done_o) begin
                    if (expQ.size() == 0 || !expQ[0].isDone) begin
                        checkOutput("unexpected done", 64'(done_o), 64'd0);
                    end else begin
                        checkOutput("cycles to done", 64'(cnt - 1), 64'(16 + stalls));
                        void'(expQ.pop_front());
                        busy = 0;
                    end
                end
                if (subkey_valid_o) begin
                    if (expQ.size() == 0 || expQ[0].isDone) begin
                        checkOutput("unexpected valid", 64'(subkey_valid_o), 64'd0);
                    end else begin
                        e = expQ[0];
                        checkOutput("subkey", 64'(subkey_o), 64'(e.subkey));
                        checkOutput("round", 64'(round_o), 64'(e.round));
                        if (subkey_ready_i) void'(expQ.pop_front());
                        else stalls++;
                    end
                end
                if (busy && cnt > 400) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL timeout: got %0d cycles expected completion", cnt);
                    expQ.delete();
                    busy = 0;
                end
                if (start_i && ready_o) begin
                    for (int p = 0; p < 16; p++) begin
                        e.isDone = 1'b0;
                        e.round  = 4'(p);
                        e.subkey = expectedSubkey(key_i, decrypt_i ? 16 - p : p + 1);
                        expQ.push_back(e);
                    end
                    e.isDone = 1'b1;
                    e.round  = 4'd0;
                    e.subkey = 48'd0;
                    expQ.push_back(e);
                    busy = 1;
                    cnt = 0;
                    stalls = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] key, input logic dec, input int stallRound,
                                 input int stallLen, input bit randomReady, input bit pulseStart,
                                 input int resetRound);
        int  left;
        bit  finished;
        for (int i = 0; i < 50 && !ready_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        key_i = key;
        decrypt_i = dec;
        start_i = 1'b1;
        subkey_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        key_i = {$urandom, $urandom};
        decrypt_i = ~dec;
        left = stallLen;
        finished = 0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (pulseStart && cyc == 3) begin
                start_i = 1'b1;
                key_i = {$urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            if (resetRound >= 0 && subkey_valid_o && int'(round_o) == resetRound) begin
                rst_n_i = 1'b0;
                @(posedge clk_i);
                @(posedge clk_i);
                #3;
                rst_n_i = 1'b1;
                finished = 1;
            end else if (subkey_valid_o && int'(round_o) == stallRound && left > 0) begin
                subkey_ready_i = 1'b0;
                left--;
            end else begin
                subkey_ready_i = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!finished) begin
                @(posedge clk_i);
                #1;
                if (done_o) finished = 1;
            end
        end
        start_i = 1'b0;
        subkey_ready_i = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int dones;
        rst_n_i = 1'b0;
        key_i = '0;
        decrypt_i = 1'b0;
        start_i = 1'b0;
        subkey_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        applyStimulus(GOLD_KEY, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus(GOLD_KEY, 1'b1, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus(GOLD_KEY, 1'b0, 7, 5, 1'b0, 1'b0, -1);
        applyStimulus(GOLD_KEY, 1'b0, -1, 0, 1'b0, 1'b1, -1);
        applyStimulus(GOLD_KEY, 1'b0, -1, 0, 1'b0, 1'b0, 9);
        applyStimulus(GOLD_KEY, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus(GOLD_KEY ^ PAR_MASK, 1'b0, -1, 0, 1'b0, 1'b0, -1);

        // start_i held high: a second schedule begins the first cycle back in IDLE.
        for (int i = 0; i < 50 && !ready_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        dones = 0;
        key_i = {$urandom, $urandom};
        decrypt_i = 1'b1;
        start_i = 1'b1;
        subkey_ready_i = 1'b1;
        for (int cyc = 0; cyc < 200 && dones < 2; cyc++) begin
            @(posedge clk_i);
            #1;
            if (done_o) dones++;
        end
        start_i = 1'b0;

        for (int n = 0; n < 8; n++) begin
            applyStimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, 0, 1'b1,
                          1'($urandom_range(0, 1)), -1);
        end

        repeat (4) @(posedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
